ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on falling edge, matching the pipeline registers.
REQ-002 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: md_start  input  1  EX-stage instruction is a mult/div/mthi/mtlo, from the ID/EX register.
REQ-004 SHALL have port: md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op.
REQ-005 SHALL have port: md_a  input  32  rs operand after forwarding (multiplicand/dividend/MT source).
REQ-006 SHALL have port: md_b  input  32  rt operand after forwarding (multiplier/divisor).
REQ-007 SHALL have port: md_flush  input  1  control-unit flush; aborts any operation in progress.
REQ-008 SHALL have port: md_busy  output  1  unit occupied; the control unit stalls IF/ID/EX on mfhi/mflo or a new md_start while high.
REQ-009 SHALL have port: md_done  output  1  one-cycle pulse when HI/LO receive a mult/div result.
REQ-010 SHALL have port: md_hi  output  32  architectural HI register.
REQ-011 SHALL have port: md_lo  output  32  architectural LO register.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX; md_busy SHALL equal (state != IDLE) and be registered.
REQ-013 In IDLE with md_start=1 and md_op 0-3: latch operand magnitudes (absolute value for signed ops, raw for unsigned), result sign flags, op, iteration count 0; go to CALC.
REQ-014 In IDLE with md_start=1 and md_op=4: md_hi<=md_a in that edge, state stays IDLE, md_busy stays 0, no md_done.
REQ-015 In IDLE with md_start=1 and md_op=5: md_lo<=md_a likewise; md_op 6-7 SHALL be ignored.
REQ-016 CALC, multiply: one shift-add step per edge over a 64-bit accumulator (radix-2); exactly 32 edges in CALC.
REQ-017 CALC, divide: one restoring step per edge (shift remainder/quotient, trial subtract 33-bit, restore on negative); exactly 32 edges in CALC.
REQ-018 After the 32nd CALC edge SHALL enter FIX; FIX edge applies signs and writes HI/LO, pulses md_done for that cycle, returns to IDLE.
REQ-019 Sign rules: MULT product negated iff sign(a)^sign(b); DIV quotient negated iff sign(a)^sign(b), remainder takes sign of dividend.
REQ-020 Result mapping: multiply HI=product[63:32], LO=product[31:0]; divide LO=quotient, HI=remainder.
REQ-021 Divide by zero (md_b=0): no fault; LO=0xFFFFFFFF, HI=md_a (natural restoring result; signed case uses unsigned-magnitude path then sign fix).
REQ-022 Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no exception.
REQ-023 Latency: start edge N, md_busy high from N through N+33, HI/LO valid and md_done high after edge N+33, md_busy low after edge N+33.
REQ-024 md_start while md_busy=1 SHALL be ignored (control unit guarantees it is stalled).
REQ-025 md_flush=1 at any edge SHALL force state IDLE, md_done 0, HI/LO unchanged; flush and start on the same edge: flush wins, start discarded.
REQ-026 md_hi/md_lo SHALL hold their values except on REQ-014/015/018 writes.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, md_busy=0, md_done=0, md_hi=0, md_lo=0, iteration count 0, regardless of operation in progress.
REQ-028 After reset release, the first falling edge with md_start=1 SHALL be accepted normally.

Verification
REQ-029 MULT a=0xFFFFFFFE (-2), b=3 -> md_busy for 34 edges, md_done once, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
REQ-032 MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive edges -> md_busy never high, HI/LO updated one edge each.
REQ-033 Start DIV, assert md_flush at CALC edge 10 -> IDLE next, md_done never pulses, HI/LO keep prior values; same with reset mid-CALC -> HI=LO=0 asynchronously.
REQ-034 md_start with new operands during CALC -> ignored, completed result reflects original operands only.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-bit multiply/divide unit owning HI/LO, one radix-2 step per falling edge.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        md_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state;
    logic [63:0] acc, mul_next, div_next, prod;
    logic [31:0] m, a_mag, b_mag, quo, rem;
    logic [32:0] sum, sh;
    logic [33:0] diff;
    logic [4:0]  cnt;
    logic        is_div, neg_q, neg_r, sgn;
    always_comb begin
        sgn      = ~md_op[0];
        a_mag    = (sgn && md_a[31]) ? -md_a : md_a;
        b_mag    = (sgn && md_b[31]) ? -md_b : md_b;
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
        mul_next = {sum, acc[31:1]};
        // Divide keeps the remainder in acc[63:32] and shifts the dividend out of acc[31:0] as quotient bits enter.
        sh       = {acc[63:32], acc[31]};
        diff     = {1'b0, sh} - {2'b0, m};
        div_next = {diff[33] ? sh[31:0] : diff[31:0], acc[30:0], ~diff[33]};
        prod     = neg_q ? -acc : acc;
        quo      = neg_q ? -acc[31:0] : acc[31:0];
        rem      = neg_r ? -acc[63:32] : acc[63:32];
    end
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            md_busy <= 1'b0;
            md_done <= 1'b0;
            md_hi   <= '0;
            md_lo   <= '0;
            acc     <= '0;
            m       <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (md_flush) begin
            state   <= IDLE;
            md_busy <= 1'b0;
            md_done <= 1'b0;
            cnt     <= '0;
        end else begin
            md_done <= 1'b0;
            case (state)
                IDLE: if (md_start) begin
                    if (!md_op[2]) begin
                        is_div  <= md_op[1];
                        acc     <= {32'd0, md_op[1] ? a_mag : b_mag};
                        m       <= md_op[1] ? b_mag : a_mag;
                        neg_q   <= sgn & (md_a[31] ^ md_b[31]);
                        neg_r   <= sgn & md_a[31];
                        cnt     <= '0;
                        state   <= CALC;
                        md_busy <= 1'b1;
                    end else if (md_op == 3'd4) md_hi <= md_a;
                    else if (md_op == 3'd5) md_lo <= md_a;
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    md_hi   <= is_div ? rem : prod[63:32];
                    md_lo   <= is_div ? quo : prod[31:0];
                    md_done <= 1'b1;
                    md_busy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector table plus hand-written flush/reset/ignore sequences for ex_muldiv.
module tb_ex_muldiv;
    logic        clk = 1'b0, reset = 1'b1, md_start = 1'b0, md_flush = 1'b0;
    logic [2:0]  md_op = '0;
    logic [31:0] md_a = '0, md_b = '0;
    logic        md_busy, md_done;
    logic [31:0] md_hi, md_lo;
    int n_cmp = 0, n_bad = 0;

    ex_muldiv dut (.clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op), .md_a(md_a),
                   .md_b(md_b), .md_flush(md_flush), .md_busy(md_busy), .md_done(md_done),
                   .md_hi(md_hi), .md_lo(md_lo));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op and returns the number of edges after the start edge until md_done is seen (0 = timeout).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(posedge clk);
        md_start = 1'b1; md_op = op; md_a = a; md_b = b;
        @(negedge clk);
        @(posedge clk);
        md_start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(negedge clk);
            @(posedge clk);
            if (md_done) lat = i;
        end
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            @(posedge clk);
        end
    endtask

    initial begin
        vec_t vecs[10];
        int lat, dones;
        vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{3'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[5] = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[6] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[7] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8] = '{3'd1, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
        vecs[9] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'd1};

        #1;
        chk("reset_busy", 64'(md_busy), 64'd0);
        chk("reset_done", 64'(md_done), 64'd0);
        chk("reset_hilo", {md_hi, md_lo}, 64'd0);
        @(posedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, lat);
            chk($sformatf("v%0d_latency", k), 64'(lat), 64'd33);
            chk($sformatf("v%0d_hi", k), 64'(md_hi), 64'(vecs[k].hi));
            chk($sformatf("v%0d_lo", k), 64'(md_lo), 64'(vecs[k].lo));
            chk($sformatf("v%0d_busy_end", k), 64'(md_busy), 64'd0);
            edges(1);
            chk($sformatf("v%0d_done_pulse", k), 64'(md_done), 64'd0);
        end

        // MTHI then MTLO on consecutive edges, then a no-op code.
        @(posedge clk);
        md_start = 1'b1; md_op = 3'd4; md_a = 32'h12345678;
        @(negedge clk); @(posedge clk);
        chk("mthi_hi", 64'(md_hi), 64'h12345678);
        chk("mthi_busy", 64'(md_busy | md_done), 64'd0);
        md_op = 3'd5; md_a = 32'h9ABCDEF0;
        @(negedge clk); @(posedge clk);
        chk("mtlo_hilo", {md_hi, md_lo}, 64'h12345678_9ABCDEF0);
        chk("mtlo_busy", 64'(md_busy | md_done), 64'd0);
        md_op = 3'd6; md_a = 32'hDEADBEEF;
        @(negedge clk); @(posedge clk);
        md_start = 1'b0;
        chk("nop_hilo", {md_hi, md_lo}, 64'h12345678_9ABCDEF0);
        chk("nop_busy", 64'(md_busy), 64'd0);

        // Flush on the 10th CALC edge of a DIV.
        @(posedge clk);
        md_start = 1'b1; md_op = 3'd2; md_a = 32'd100; md_b = 32'd3;
        @(negedge clk); @(posedge clk);
        md_start = 1'b0;
        chk("flush_busy_start", 64'(md_busy), 64'd1);
        edges(9);
        md_flush = 1'b1;
        @(negedge clk); @(posedge clk);
        md_flush = 1'b0;
        chk("flush_busy", 64'(md_busy), 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); @(posedge clk);
            dones += int'(md_done) + int'(md_busy);
        end
        chk("flush_no_done", 64'(dones), 64'd0);
        chk("flush_hilo", {md_hi, md_lo}, 64'h12345678_9ABCDEF0);

        // Flush and start together: start discarded.
        @(posedge clk);
        md_start = 1'b1; md_flush = 1'b1; md_op = 3'd4; md_a = 32'h55555555;
        @(negedge clk); @(posedge clk);
        md_start = 1'b0; md_flush = 1'b0;
        chk("flush_start_busy", 64'(md_busy), 64'd0);
        chk("flush_start_hilo", {md_hi, md_lo}, 64'h12345678_9ABCDEF0);

        // A start during CALC must not disturb the running MULTU.
        @(posedge clk);
        md_start = 1'b1; md_op = 3'd1; md_a = 32'd3; md_b = 32'd5;
        @(negedge clk); @(posedge clk);
        md_start = 1'b0;
        edges(4);
        md_start = 1'b1; md_op = 3'd3; md_a = 32'd1000; md_b = 32'd9;
        @(negedge clk); @(posedge clk);
        md_start = 1'b0;
        lat = 0;
        for (int i = 6; i <= 60 && lat == 0; i++) begin
            @(negedge clk); @(posedge clk);
            if (md_done) lat = i;
        end
        chk("ignore_latency", 64'(lat), 64'd33);
        chk("ignore_hilo", {md_hi, md_lo}, 64'd15);

        // Asynchronous reset in mid-CALC clears HI/LO at once.
        @(posedge clk);
        md_start = 1'b1; md_op = 3'd0; md_a = 32'd9; md_b = 32'd9;
        @(negedge clk); @(posedge clk);
        md_start = 1'b0;
        edges(5);
        #1 reset = 1'b1;
        #1;
        chk("areset_busy", 64'(md_busy), 64'd0);
        chk("areset_hilo", {md_hi, md_lo}, 64'd0);
        @(posedge clk);
        reset = 1'b0;
        run_op(3'd1, 32'd6, 32'd7, lat);
        chk("post_reset_latency", 64'(lat), 64'd33);
        chk("post_reset_hilo", {md_hi, md_lo}, 64'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
